ntt_butterfly_combine: RTL

NTT_BUTTERFLY_COMBINE -- requirements
Module: ntt_butterfly_combine

---
 rtl/ntt_butterfly_combine_if.sv | 31 +++
 rtl/ntt_butterfly_combine.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ntt_butterfly_combine_if.sv
// ---------------------------------------------------------------------------
// ntt_butterfly_combine_if
// Bus bundle for the NTT butterfly combine stage.
//   issue_valid / issue_a : butterfly issued, upper operand a
//   prod_valid  / prod    : modular product w*b mod q from the multiplier
//   out_valid / out_x / out_y : combined butterfly result
// Modports:
//   master : issuer/multiplier side (drives issue/prod, observes results)
//   slave  : the combine block (consumes issue/prod, drives results)
// ---------------------------------------------------------------------------
interface ntt_butterfly_combine_if #(
    parameter int DATA_WIDTH = 12
) ();
    logic                  issue_valid;
    logic [DATA_WIDTH-1:0] issue_a;
    logic                  prod_valid;
    logic [DATA_WIDTH-1:0] prod;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_x;
    logic [DATA_WIDTH-1:0] out_y;

    modport master (
        output issue_valid, issue_a, prod_valid, prod,
        input  out_valid, out_x, out_y
    );

    modport slave (
        input  issue_valid, issue_a, prod_valid, prod,
        output out_valid, out_x, out_y
    );
endinterface

// File: rtl/ntt_butterfly_combine.sv
// ---------------------------------------------------------------------------
// ntt_butterfly_combine
// Holds the upper butterfly operand a in a FIFO while the lower operand goes
// through a pipelined modular multiplier, then pairs each returning product
// (in issue order) with the oldest held a and produces
//   out_x = (a + prod) mod q,  out_y = (a - prod) mod q
// one cycle after the product arrives.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   enable        : global advance (no push/pop, no output when low)
//   clear         : synchronous flush of FIFO and sticky error flags
//   bus (slave)   : issue_*, prod_*, out_* handshake/data signals
//   fifo_count    : number of held operands
//   overflow_err  : sticky, an issue was dropped because the FIFO was full
//   underflow_err : sticky, a product arrived with nothing held
// DEPTH must be a power of two (pointers wrap naturally) and at least 2.
// ---------------------------------------------------------------------------
module ntt_butterfly_combine #(
    parameter int DATA_WIDTH = 12,
    parameter int MODULUS    = 3329,
    parameter int DEPTH      = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     clear,
    ntt_butterfly_combine_if.slave   bus,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow_err,
    output logic                     underflow_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [DATA_WIDTH:0] MOD_L   = (DATA_WIDTH + 1)'(MODULUS);
    localparam logic [CNT_W-1:0]    DEPTH_L = CNT_W'(DEPTH);

    // (a + b) mod q for a, b < q, using one conditional subtract
    function automatic logic [DATA_WIDTH-1:0] mod_add(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= MOD_L) begin
            return DATA_WIDTH'(s - MOD_L);
        end else begin
            return DATA_WIDTH'(s);
        end
    endfunction

    // (a - b) mod q for a, b < q; the +q path stays positive at DATA_WIDTH+1 bits
    function automatic logic [DATA_WIDTH-1:0] mod_sub(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        if (a >= b) begin
            return DATA_WIDTH'({1'b0, a} - {1'b0, b});
        end else begin
            return DATA_WIDTH'({1'b0, a} + MOD_L - {1'b0, b});
        end
    endfunction

    logic [DATA_WIDTH-1:0] fifo_mem [DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_x_q, out_x_d;
    logic [DATA_WIDTH-1:0] out_y_q, out_y_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic                  active_s;
    logic                  pop_s;
    logic                  push_s;
    logic [DATA_WIDTH-1:0] head_a_s;

    // Push/pop decisions, error detection and next-state computation
    always_comb begin
        active_s = enable && !clear;
        // Pop decision uses the count before any same-cycle push, so the
        // entry written this cycle can never be the one read.
        pop_s    = active_s && bus.prod_valid && (count_q != {CNT_W{1'b0}});
        push_s   = active_s && bus.issue_valid && ((count_q < DEPTH_L) || pop_s);
        head_a_s = fifo_mem[rd_ptr_q];

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = pop_s;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;

        if (clear) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                out_x_d  = mod_add(head_a_s, bus.prod);
                out_y_d  = mod_sub(head_a_s, bus.prod);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_s && !pop_s) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop_s && !push_s) begin
                count_d = count_q - CNT_W'(1);
            end else begin
                count_d = count_q;
            end
            if (active_s && bus.issue_valid && !push_s) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
            if (active_s && bus.prod_valid && (count_q == {CNT_W{1'b0}})) begin
                unf_d = 1'b1;
            end else begin
                unf_d = unf_q;
            end
        end
    end

    // Control/output state registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            out_valid_q <= 1'b0;
            out_x_q     <= {DATA_WIDTH{1'b0}};
            out_y_q     <= {DATA_WIDTH{1'b0}};
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    // Operand storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem[wr_ptr_q] <= bus.issue_a;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_x      = out_x_q;
    assign bus.out_y      = out_y_q;
    assign fifo_count     = count_q;
    assign overflow_err   = ovf_q;
    assign underflow_err  = unf_q;
endmodule
